dcache_data_array: RTL

Parametrised, multi-way data storage for the data cache, with per-byte write strobes on the CPU port and an internal line-burst sequencer for refill and write-back. It sits between the dcache controller, which issues CPU word accesses, and the bus interface, which streams whole lines in and out. It replaces the single-way word RAM with a way-indexed array. Whole-line transfers run autonomously, one word per cycle, under valid/ready handshakes.

---
 rtl/dcache_data_array.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_data_array.sv
// ---------------------------------------------------------------------------
// dcache_data_array
//   Way-indexed data storage for the data cache. A CPU port does single-word
//   read-first accesses with byte strobes. A burst sequencer moves whole lines
//   one word per cycle: FILL writes beats coming from the bus, EVICT streams a
//   line out to the bus.
//
// State table
//   state | meaning
//   IDLE  | CPU port live, waiting for a burst start
//   FILL  | refill in progress, one beat written per fill_valid_i
//   EVICT | write-back in progress, one word per evict handshake
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_i, wr_en_i                CPU access request / write qualifier
//   way_i, line_i, word_i         CPU word address
//   wstrb_i, wdata_i              CPU byte strobes and write data
//   rdata_o, rvalid_o             CPU read data and one-cycle valid pulse
//   busy_o                        burst in progress, CPU port ignored
//   fill_start_i, evict_start_i   burst starts (evict wins if both)
//   burst_way_i, burst_line_i     burst target, sampled on start
//   fill_valid_i/fill_data_i/fill_ready_o     refill beat handshake
//   evict_valid_o/evict_data_o/evict_ready_i  write-back beat handshake
//   fill_done_o, evict_done_o     one-cycle completion pulses
// ---------------------------------------------------------------------------
module dcache_data_array #(
    parameter int WAYS   = 4,
    parameter int LINES  = 64,
    parameter int WORDS  = 16,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int WORD_W = $clog2(WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              wr_en_i,
    input  logic [WAY_W-1:0]  way_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              busy_o,
    input  logic              fill_start_i,
    input  logic              evict_start_i,
    input  logic [WAY_W-1:0]  burst_way_i,
    input  logic [LINE_W-1:0] burst_line_i,
    input  logic              fill_valid_i,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              fill_ready_o,
    output logic              evict_valid_o,
    output logic [DATA_W-1:0] evict_data_o,
    input  logic              evict_ready_i,
    output logic              fill_done_o,
    output logic              evict_done_o
);

    localparam int DEPTH  = WAYS * LINES * WORDS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [WORD_W-1:0] CNT_LAST = WORD_W'(WORDS - 1);
    localparam logic [WORD_W-1:0] CNT_ONE  = WORD_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        EVICT = 2'd2
    } state_e;

    function automatic logic [ADDR_W-1:0] flat_addr(
        input logic [WAY_W-1:0]  way,
        input logic [LINE_W-1:0] line,
        input logic [WORD_W-1:0] word
    );
        return (ADDR_W'(way) * ADDR_W'(LINES) + ADDR_W'(line)) * ADDR_W'(WORDS)
               + ADDR_W'(word);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] evict_data_q;
    logic              rvalid_q;
    logic              fill_done_q, fill_done_d;
    logic              evict_done_q, evict_done_d;

    // single shared read port and write port
    logic              cpu_rd;
    logic              ev_rd;
    logic [ADDR_W-1:0] rd_addr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    always_comb begin
        state_d      = state_q;
        way_d        = way_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        cpu_rd       = 1'b0;
        ev_rd        = 1'b0;
        rd_addr      = flat_addr(way_q, line_q, cnt_q + CNT_ONE);
        we           = 1'b0;
        waddr        = flat_addr(way_q, line_q, cnt_q);
        wdata        = fill_data_i;
        wstrb        = '1;
        fill_done_d  = 1'b0;
        evict_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (evict_start_i) begin
                    state_d = EVICT;
                    way_d   = burst_way_i;
                    line_d  = burst_line_i;
                    cnt_d   = '0;
                    // prefetch word 0 so it is presented the cycle after start
                    ev_rd   = 1'b1;
                    rd_addr = flat_addr(burst_way_i, burst_line_i, '0);
                end else if (fill_start_i) begin
                    state_d = FILL;
                    way_d   = burst_way_i;
                    line_d  = burst_line_i;
                    cnt_d   = '0;
                end else if (req_i) begin
                    cpu_rd  = 1'b1;
                    rd_addr = flat_addr(way_i, line_i, word_i);
                    we      = wr_en_i;
                    waddr   = flat_addr(way_i, line_i, word_i);
                    wdata   = wdata_i;
                    wstrb   = wstrb_i;
                end
            end
            FILL: begin
                if (fill_valid_i) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end
            EVICT: begin
                if (evict_ready_i) begin
                    if (cnt_q != CNT_LAST) begin
                        ev_rd = 1'b1;
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        state_d      = IDLE;
                        cnt_d        = '0;
                        evict_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is not reset; writes are blocked during reset so an aborted
    // fill leaves earlier beats intact and drops the beat coinciding with reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            way_q        <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            evict_data_q <= '0;
            fill_done_q  <= 1'b0;
            evict_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            way_q        <= way_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            rvalid_q     <= cpu_rd;
            fill_done_q  <= fill_done_d;
            evict_done_q <= evict_done_d;
            // reads sample the pre-write contents (read-first)
            if (cpu_rd) begin
                rdata_q <= mem_q[rd_addr];
            end
            if (ev_rd) begin
                evict_data_q <= mem_q[rd_addr];
            end
        end
    end

    assign rdata_o       = rdata_q;
    assign rvalid_o      = rvalid_q;
    assign busy_o        = (state_q != IDLE);
    assign fill_ready_o  = (state_q == FILL);
    assign evict_valid_o = (state_q == EVICT);
    assign evict_data_o  = evict_data_q;
    assign fill_done_o   = fill_done_q;
    assign evict_done_o  = evict_done_q;

endmodule
